// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: shared sizes, state encoding and halt-opcode decode for cpu_memory
package simple_cpu_pkg;
    localparam int MEMSIZE = 64;
    localparam int AW = 6;
    // halt opcodes: bit7=1 and bits[6:4] in {011,111}, so bit6 is a don't-care
    localparam logic [7:0] HALT_MASK = 8'hB0;
    localparam logic [7:0] HALT_MATCH = 8'hB0;
    typedef enum logic [1:0] {LOAD, RUN, HALT} mem_state_t;
    function automatic logic is_halt(input logic [7:0] op);
        return (op & HALT_MASK) == HALT_MATCH;
    endfunction
endpackage

// File: rtl/cpu_program_loader.sv
// cpu_program_loader: byte-serial valid/ready program loader with byte count and termination detect
module cpu_program_loader
    import simple_cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          active,
    input  logic          clear,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic [AW:0]   load_count,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [7:0]    wdata,
    output logic          load_done
);
    logic [AW:0] count_q, count_d;
    assign load_ready = active;
    assign we = load_valid && active;
    assign waddr = count_q[AW-1:0];
    assign wdata = load_data;
    assign load_done = we && (load_last || count_q == 7'(MEMSIZE - 1));
    assign load_count = count_q;
    // next byte count: cleared on restart, advanced on each accepted byte
    always_comb begin
        count_d = clear ? '0 : we ? count_q + 7'd1 : count_q;
    end
    // count register
    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else count_q <= count_d;
    end
endmodule

// File: rtl/cpu_memory.sv
// cpu_memory: 64-byte unified memory with program loader and run/halt control; CPU_MEM_PROTECT_EN adds code-region store protection
module cpu_memory
    import simple_cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    input  logic [7:0]         load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic               restart,
    input  logic               write_flag,
    input  logic [MEMSIZE-1:0] write_addr,
    input  logic [7:0]         write_value,
    input  logic [7:0]         ip,
    output logic [7:0]         memory [MEMSIZE],
    output logic               cpu_run,
    output logic               halted,
    output logic [6:0]         load_count,
    output logic               protect_fault
);
    mem_state_t state_q, state_d;
    logic [7:0] mem_q [MEMSIZE];
    logic [7:0] mem_d [MEMSIZE];
    logic ld_we, ld_done, store_ok;
    logic [AW-1:0] ld_addr;
    logic [7:0] ld_data;
    logic in_load, in_run, in_halt, halt_hit, do_restart;
    logic unused_bits;
    assign unused_bits = ^{write_addr[MEMSIZE-1:AW], ip[7:AW]};
    assign in_load = state_q == LOAD;
    assign in_run = state_q == RUN;
    assign in_halt = state_q == HALT;
    assign halt_hit = is_halt(mem_q[ip[AW-1:0]]);
    assign do_restart = in_halt && restart;
    cpu_program_loader u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .active     (in_load),
        .clear      (do_restart),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_count (load_count),
        .we         (ld_we),
        .waddr      (ld_addr),
        .wdata      (ld_data),
        .load_done  (ld_done)
    );
`ifdef CPU_MEM_PROTECT_EN
    logic [AW:0] code_end_q, code_end_d;
    logic fault_q, fault_d, store_block;
    // the loaded program occupies [0, code_end); run-time stores into it are dropped and flagged
    always_comb begin
        store_block = {1'b0, write_addr[AW-1:0]} < code_end_q;
        store_ok = in_run && write_flag && !store_block;
        code_end_d = ld_done ? load_count + 7'd1 : code_end_q;
        fault_d = do_restart ? 1'b0 : fault_q || (in_run && write_flag && store_block);
    end
    // protection registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_end_q <= '0;
            fault_q <= 1'b0;
        end else begin
            code_end_q <= code_end_d;
            fault_q <= fault_d;
        end
    end
    assign protect_fault = fault_q;
`else
    assign store_ok = in_run && write_flag;
    assign protect_fault = 1'b0;
`endif
    // LOAD->RUN on the terminating byte, RUN->HALT on a halt opcode at ip, HALT->LOAD on restart
    always_comb begin
        state_d = in_load && ld_done ? RUN : in_run && halt_hit ? HALT : do_restart ? LOAD : state_q;
    end
    // loader and CPU stores never coincide since they are gated by different states
    always_comb begin
        mem_d = mem_q;
        if (ld_we) mem_d[ld_addr] = ld_data;
        if (store_ok) mem_d[write_addr[AW-1:0]] = write_value;
    end
    // state and memory image
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            mem_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            mem_q <= mem_d;
        end
    end
    assign memory = mem_q;
    assign cpu_run = in_run;
    assign halted = in_halt;
endmodule

// File: tb/tb_cpu_memory.sv
// tb_cpu_memory: directed bench for cpu_memory with a behavioural reference checked every cycle
module tb_cpu_memory;
    logic clk = 0, rst_n = 0;
    logic load_valid = 0, load_last = 0, load_ready, restart = 0, write_flag = 0;
    logic [7:0] load_data = 0, write_value = 0, ip = 0;
    logic [63:0] write_addr = 0;
    logic [7:0] memory [64];
    logic cpu_run, halted, protect_fault;
    logic [6:0] load_count;
    int n_checks = 0, n_fail = 0;
    bit chk_en = 0;

    cpu_memory dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .restart(restart),
        .write_flag(write_flag), .write_addr(write_addr), .write_value(write_value),
        .ip(ip), .memory(memory), .cpu_run(cpu_run), .halted(halted),
        .load_count(load_count), .protect_fault(protect_fault)
    );

    always #5 clk = ~clk;

    // reference: 0=LOAD 1=RUN 2=HALT
    int m_state = 0, m_cnt = 0, m_end = 0;
    bit m_fault = 0;
    byte unsigned m_mem [64];

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_state = 0; m_cnt = 0; m_end = 0; m_fault = 0;
        end else if (m_state == 0) begin
            if (load_valid) begin
                m_mem[m_cnt] = load_data;
                m_cnt++;
                if (load_last || m_cnt == 64) begin
                    m_state = 1;
                    m_end = m_cnt;
                end
            end
        end else if (m_state == 1) begin
            byte unsigned op;
            int a;
            op = m_mem[ip % 64];
            a = int'(write_addr[5:0]);
            if (write_flag) begin
`ifdef CPU_MEM_PROTECT_EN
                if (a < m_end) m_fault = 1;
                else m_mem[a] = write_value;
`else
                m_mem[a] = write_value;
`endif
            end
            if (op[7] && (op[6:4] == 3'b011 || op[6:4] == 3'b111)) m_state = 2;
        end else if (restart) begin
            m_state = 0; m_cnt = 0; m_fault = 0;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        int bad;
        bad = -1;
        check("model_load_ready", int'(load_ready), int'(m_state == 0));
        check("model_cpu_run", int'(cpu_run), int'(m_state == 1));
        check("model_halted", int'(halted), int'(m_state == 2));
        check("model_load_count", int'(load_count), m_cnt);
        check("model_protect_fault", int'(protect_fault), int'(m_fault));
        for (int i = 63; i >= 0; i--) if (memory[i] !== m_mem[i]) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL model_memory[%0d]: got %0h want %0h", bad, memory[bad], m_mem[bad]);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        byte unsigned prog [3] = '{8'h50, 8'h05, 8'hF0};
        int nz;
        @(posedge clk);
        chk_en = 1;
        #1;
        tick;
        rst_n = 1;
        @(negedge clk);
        check("rst_load_ready", int'(load_ready), 1);
        check("rst_load_count", int'(load_count), 0);
        check("rst_cpu_run", int'(cpu_run), 0);
        check("rst_halted", int'(halted), 0);
        // three-byte program
        for (int i = 0; i < 3; i++) begin
            load_valid = 1; load_data = prog[i]; load_last = (i == 2);
            tick;
        end
        load_valid = 0; load_last = 0;
        @(negedge clk);
        check("ld3_mem0", int'(memory[0]), 'h50);
        check("ld3_mem1", int'(memory[1]), 'h05);
        check("ld3_mem2", int'(memory[2]), 'hF0);
        check("ld3_count", int'(load_count), 3);
        check("ld3_cpu_run", int'(cpu_run), 1);
        check("ld3_ready", int'(load_ready), 0);
        // store with junk above bit 5: lands at 63
        write_flag = 1; write_addr = 64'hFFFF_0000_0000_00FF; write_value = 8'hA5;
        tick;
        write_flag = 0;
        @(negedge clk);
        check("store_mem63", int'(memory[63]), 'hA5);
        tick; tick;
        @(negedge clk);
        check("nostore_mem63", int'(memory[63]), 'hA5);
        // restart outside HALT is ignored
        restart = 1;
        tick;
        restart = 0;
        @(negedge clk);
        check("restart_ign_run", int'(cpu_run), 1);
        // ip 0x42 wraps to 2 (0xF0 = halt); store in the same cycle still commits
        ip = 8'h42; write_flag = 1; write_addr = 64'd10; write_value = 8'h77;
        tick;
        write_flag = 0;
        @(negedge clk);
        check("halt_halted", int'(halted), 1);
        check("halt_cpu_run", int'(cpu_run), 0);
        check("halt_store_mem10", int'(memory[10]), 'h77);
        write_flag = 1; write_addr = 64'd11; write_value = 8'h99;
        tick;
        write_flag = 0;
        @(negedge clk);
        check("halt_frozen_mem11", int'(memory[11]), 0);
        restart = 1;
        tick;
        restart = 0;
        @(negedge clk);
        check("restart_count", int'(load_count), 0);
        check("restart_ready", int'(load_ready), 1);
        check("restart_halted", int'(halted), 0);
        check("restart_keep_mem2", int'(memory[2]), 'hF0);
        // 70-byte stream without last: only 64 accepted
        for (int i = 0; i < 70; i++) begin
            load_valid = 1; load_data = 8'(i + 1); load_last = 0;
            tick;
            if (i == 63) begin
                @(negedge clk);
                check("full_ready_low", int'(load_ready), 0);
                check("full_count", int'(load_count), 64);
            end
        end
        load_valid = 0;
        @(negedge clk);
        check("full_mem0", int'(memory[0]), 1);
        check("full_mem63", int'(memory[63]), 'h40);
        check("full_cpu_run", int'(cpu_run), 1);
        // store then reset mid-run
        write_flag = 1; write_addr = 64'd5; write_value = 8'h11;
        tick;
        write_flag = 0;
`ifndef CPU_MEM_PROTECT_EN
        @(negedge clk);
        check("run_store_mem5", int'(memory[5]), 'h11);
`endif
        rst_n = 0;
        tick;
        rst_n = 1;
        @(negedge clk);
        nz = 0;
        foreach (memory[i]) if (memory[i] != 0) nz++;
        check("rst_mem_nonzero", nz, 0);
        check("rst2_ready", int'(load_ready), 1);
        check("rst2_count", int'(load_count), 0);
        check("rst2_cpu_run", int'(cpu_run), 0);
`ifdef CPU_MEM_PROTECT_EN
        ip = 0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1; load_data = prog[i]; load_last = (i == 2);
            tick;
        end
        load_valid = 0; load_last = 0;
        write_flag = 1; write_addr = 64'd1; write_value = 8'hEE;
        tick;
        write_flag = 0;
        @(negedge clk);
        check("prot_mem1", int'(memory[1]), 'h05);
        check("prot_fault", int'(protect_fault), 1);
        write_flag = 1; write_addr = 64'd3; write_value = 8'hEE;
        tick;
        write_flag = 0;
        @(negedge clk);
        check("prot_mem3", int'(memory[3]), 'hEE);
`endif
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
